uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter sharing one `uart_tx` transmitter between `NUM_REQ` byte producers. Selects a pending requester, latches its byte, drives `data_to_tx`/`start_tx` with a handshake that tolerates the transmitter's slower baud-clock domain, and acknowledges the requester once the transmitter reports busy. Sits between the control/telemetry logic and the `uart_tx` instance in the FPGA top level.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `START_TIMEOUT`, 4096: clk cycles to wait for `tx_busy` rise after `start_tx`; must exceed two baud periods.
- `clk` in 1: system clock; same clock that feeds the `uart_tx` divider.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester byte pending.
- `req_data` in 8*NUM_REQ: byte of requester i at [8i+7:8i].
- `req_last` in NUM_REQ: present only with `UART_ARB_LOCK_EN`; marks final byte of a packet.
- `req_ack` out NUM_REQ: one-cycle pulse; byte of that requester accepted by transmitter.
- `grant` out NUM_REQ: one-hot owner of current transfer, 0 when idle.
- `data_to_tx` out 8: to `uart_tx.data_to_tx`.
- `start_tx` out 1: to `uart_tx.start_tx`.
- `tx_busy` in 1: from `uart_tx.tx_busy`, asynchronous to this logic.
- `tx_err` out 1: one-cycle pulse on start timeout.

## Operation
- `tx_busy` passes a 2-flop synchronizer; `busy_s` denotes its output. All decisions use `busy_s`.
- States: IDLE, START, WAIT_DONE.
- IDLE: if `busy_s`=0 and any `req_valid`, winner = first set bit searching upward (wrapping) from `ptr`. Register `data_to_tx`=winner's byte, `grant`=one-hot(winner), `start_tx`=1, clear timeout counter -> START.
- START: `busy_s`=1 -> `start_tx`=0, `req_ack[winner]` pulse, `ptr`=winner+1 mod NUM_REQ -> WAIT_DONE. Counter reaches `START_TIMEOUT` -> `start_tx`=0, `grant`=0, `tx_err` pulse, no ack, `ptr` unchanged -> IDLE.
- WAIT_DONE: `busy_s`=0 -> `grant`=0 -> IDLE.
- Byte is latched at grant; requester changing `req_data` or dropping `req_valid` afterwards has no effect on the transfer; ack still issued.
- Requester holds `req_valid`/`req_data` until `req_ack`; for the next byte it presents new data the cycle after ack.
- `data_to_tx` holds its value from grant until the next grant.
- `grant` bits outside NUM_REQ never set; `req_valid` of unsupported indices ignored.

## Timing
- Reset values: `start_tx`=0, `data_to_tx`=0, `grant`=0, `req_ack`=0, `tx_err`=0, state IDLE, `ptr`=0, synchronizer 0.
- `start_tx` rises 1 clk after `req_valid` seen in IDLE.
- `req_ack` follows `tx_busy` rise by 3 clk (2 sync + 1 register).
- Minimum gap between grants: `busy_s` fall + 1 clk.
- Simultaneous requests resolved in the same cycle by `ptr`; ack and new request of same requester in one cycle: request not considered until back in IDLE.
- Reset mid-transfer: outputs return to reset values immediately; the in-flight UART frame completes on its own, and IDLE waits for `busy_s`=0 before granting.

## Configuration
- `UART_ARB_LOCK_EN` defined: `req_last` port exists; after ack of a byte with `req_last`=0, `ptr` stays on the winner and IDLE grants only that requester (others blocked) until a byte with `req_last`=1 is acked; timeout releases the lock.
- Undefined: no `req_last` port; pure per-byte round-robin.

## Test plan
- Single requester 2 sends 0xA5 -> `start_tx` 1 clk later, `data_to_tx`=0xA5, `grant`=0b0100, one `req_ack[2]` pulse 3 clk after `tx_busy` rise.
- All four valid at reset release with 0x10..0x13 -> transmit order 0x10,0x11,0x12,0x13; then requester 0 and 3 again -> 3 served before 0? No: `ptr`=0 -> 0 then 3.
- `tx_busy` tied 0 -> `start_tx` high exactly 4096 clk, then `tx_err` pulse, no ack, same requester retried.
- Reset asserted during WAIT_DONE with `tx_busy`=1 -> all outputs 0 at once; after release no grant until `tx_busy` low.
- `UART_ARB_LOCK_EN`: requester 1 sends 3 bytes (last on third) while 0 pending -> 1,1,1 then 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side bundle of uart_tx_arbiter.
// UART_ARB_LOCK_EN adds req_last for packet locking.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   req_last;
`endif
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           data_to_tx;
    logic                 start_tx;
    logic                 tx_busy;
    logic                 tx_err;

`ifdef UART_ARB_LOCK_EN
    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ack, grant, data_to_tx, start_tx, tx_err
    );
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ack, grant, data_to_tx, start_tx, tx_err
    );
`else
    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ack, grant, data_to_tx, start_tx, tx_err
    );
    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ack, grant, data_to_tx, start_tx, tx_err
    );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// UART_ARB_LOCK_EN: hold the grant on one requester until its req_last byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4096
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } state_t;

    state_t state, state_n;

    logic busy_m, busy_s;
    logic [1:0] armed;

    logic [PW-1:0] ptr, ptr_n;
    logic [PW-1:0] win, win_n;
    logic [PW-1:0] pick;
    logic [PW-1:0] win_inc;
    logic found;

    logic [CW-1:0] cnt, cnt_n;
    logic [7:0] data_q, data_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic [NUM_REQ-1:0] ack_q, ack_n;
    logic [NUM_REQ-1:0] elig;
    logic start_q, start_n;
    logic err_q, err_n;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_n;
    logic last_q, last_n;
    logic [NUM_REQ-1:0] ptr_oh;
`endif

    // tx_busy comes from the baud domain; only busy_s is trusted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
            armed  <= 2'b00;
        end else begin
            busy_m <= bus.tx_busy;
            busy_s <= busy_m;
            armed  <= {armed[0], 1'b1};
        end
    end

`ifdef UART_ARB_LOCK_EN
    always_comb begin
        ptr_oh = '0;
        ptr_oh[ptr] = 1'b1;
        elig = lock_q ? (bus.req_valid & ptr_oh) : bus.req_valid;
    end
`else
    assign elig = bus.req_valid;
`endif

    always_comb begin
        logic [PW-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign win_inc = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        win_n   = win;
        cnt_n   = cnt;
        data_n  = data_q;
        grant_n = grant_q;
        ack_n   = '0;
        start_n = start_q;
        err_n   = 1'b0;
`ifdef UART_ARB_LOCK_EN
        lock_n  = lock_q;
        last_n  = last_q;
`endif
        unique case (state)
            IDLE: begin
                // armed holds off grants until the synchronizer has
                // seen the line, so a frame still running from before
                // reset is not clobbered.
                if (armed[1] && !busy_s && found) begin
                    win_n   = pick;
                    data_n  = bus.req_data[8*pick +: 8];
                    grant_n = '0;
                    grant_n[pick] = 1'b1;
                    start_n = 1'b1;
                    cnt_n   = '0;
`ifdef UART_ARB_LOCK_EN
                    last_n  = bus.req_last[pick];
`endif
                    state_n = START;
                end
            end
            START: begin
                if (busy_s) begin
                    start_n    = 1'b0;
                    ack_n[win] = 1'b1;
`ifdef UART_ARB_LOCK_EN
                    if (last_q) begin
                        ptr_n  = win_inc;
                        lock_n = 1'b0;
                    end else begin
                        ptr_n  = win;
                        lock_n = 1'b1;
                    end
`else
                    ptr_n = win_inc;
`endif
                    state_n = WAIT_DONE;
                end else if (cnt == CW'(START_TIMEOUT - 1)) begin
                    start_n = 1'b0;
                    grant_n = '0;
                    err_n   = 1'b1;
`ifdef UART_ARB_LOCK_EN
                    lock_n  = 1'b0;
`endif
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!busy_s) begin
                    grant_n = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            cnt     <= '0;
            data_q  <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= 1'b0;
            last_q  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            win     <= win_n;
            cnt     <= cnt_n;
            data_q  <= data_n;
            grant_q <= grant_n;
            ack_q   <= ack_n;
            start_q <= start_n;
            err_q   <= err_n;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= lock_n;
            last_q  <= last_n;
`endif
        end
    end

    assign bus.data_to_tx = data_q;
    assign bus.start_tx   = start_q;
    assign bus.grant      = grant_q;
    assign bus.req_ack    = ack_q;
    assign bus.tx_err     = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vectors, corner sequences and a
// randomized run against a queue-based round-robin model.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int TMO = 4096;

    typedef struct {
        int           idx;
        logic [7:0]   data;
        logic [N-1:0] grant;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    int npass = 0;
    int ntot = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int mptr = 0;
    bit mlock = 1'b0;

    logic [7:0] qd [N][8];
    int qn [N];
`ifdef UART_ARB_LOCK_EN
    bit ql [N][8];
`endif

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .START_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
`ifdef UART_ARB_LOCK_EN
        bus.req_last  = '0;
`endif
        tick();
        tick();
        reset = 1'b1;
        mptr  = 0;
        mlock = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic present(input int i, input int h);
        if (h < qn[i]) begin
            bus.req_valid[i] = 1'b1;
            bus.req_data[8*i +: 8] = qd[i][h];
`ifdef UART_ARB_LOCK_EN
            bus.req_last[i] = ql[i][h];
`endif
        end else begin
            bus.req_valid[i] = 1'b0;
        end
    endtask

    // Model: all queued bytes are pending at every decision, so the
    // expected order is a pure pointer walk over non-empty queues.
    task automatic run_engine(input string tag);
        int mh [N];
        int dh [N];
        int ei [64];
        logic [7:0] ed [64];
        int en;
        int pos;
        int ust;
        int ucnt;
        int c;
        int w;
        int ii;
        int a;
        en = 0;
        pos = 0;
        ust = 0;
        ucnt = 0;
        for (int i = 0; i < N; i++) begin
            mh[i] = 0;
            dh[i] = 0;
        end
        for (int s = 0; s < 64; s++) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                ii = (mptr + k) % N;
                if (w < 0 && !(mlock && k != 0) && mh[ii] < qn[ii]) w = ii;
            end
            if (w >= 0) begin
                ei[en] = w;
                ed[en] = qd[w][mh[w]];
`ifdef UART_ARB_LOCK_EN
                if (ql[w][mh[w]]) begin
                    mptr  = (w + 1) % N;
                    mlock = 1'b0;
                end else begin
                    mptr  = w;
                    mlock = 1'b1;
                end
`else
                mptr = (w + 1) % N;
`endif
                mh[w]++;
                en++;
            end
        end
        for (int i = 0; i < N; i++) present(i, 0);
        c = 0;
        while (c < 5000 && !(pos == en && ust == 0 && bus.grant == '0)) begin
            tick();
            c++;
            if (bus.req_ack != '0) begin
                a = 0;
                for (int i = 0; i < N; i++) if (bus.req_ack[i]) a = i;
                chk({tag, "_ack_onehot"}, $countones(bus.req_ack), 1);
                chk({tag, "_ack_lat"}, cyc - rise_cyc, 3);
                chk({tag, "_ack_grant"}, 32'(bus.grant), 32'(bus.req_ack));
                if (pos < en) begin
                    chk({tag, "_who"}, a, ei[pos]);
                    chk({tag, "_byte"}, 32'(bus.data_to_tx), 32'(ed[pos]));
                end else begin
                    chk({tag, "_extra_ack"}, pos, en);
                end
                pos++;
                dh[a]++;
                present(a, dh[a]);
            end
            case (ust)
                0: if (bus.start_tx) begin
                    ucnt = $urandom_range(3, 0);
                    ust = 1;
                end
                1: if (ucnt == 0) begin
                    bus.tx_busy = 1'b1;
                    rise_cyc = cyc;
                    ucnt = $urandom_range(10, 4);
                    ust = 2;
                end else ucnt--;
                2: if (ucnt == 0) begin
                    bus.tx_busy = 1'b0;
                    ust = 0;
                end else ucnt--;
                default: ust = 0;
            endcase
        end
        chk({tag, "_done"}, pos, en);
        bus.tx_busy = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        vec_t tbl [4];
        vec_t v;
        int n;
        logic seen;

        tbl[0] = '{2, 8'hA5, 4'b0100};
        tbl[1] = '{0, 8'h3C, 4'b0001};
        tbl[2] = '{3, 8'hFF, 4'b1000};
        tbl[3] = '{1, 8'h00, 4'b0010};

        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
`ifdef UART_ARB_LOCK_EN
        bus.req_last  = '0;
`endif
        tick();
        tick();
        chk("reset_outputs", 32'({bus.start_tx, bus.grant, bus.data_to_tx,
                                  bus.req_ack, bus.tx_err}), 0);
        reset = 1'b1;
        tick();
        tick();
        tick();

        // single-requester vectors
`ifdef UART_ARB_LOCK_EN
        bus.req_last = '1;
`endif
        for (int e = 0; e < 4; e++) begin
            v = tbl[e];
            bus.req_valid[v.idx] = 1'b1;
            bus.req_data[8*v.idx +: 8] = v.data;
            tick();
            chk("vec_start", 32'(bus.start_tx), 1);
            chk("vec_grant", 32'(bus.grant), 32'(v.grant));
            chk("vec_data", 32'(bus.data_to_tx), 32'(v.data));
            bus.req_data[8*v.idx +: 8] = ~v.data;
            tick();
            tick();
            bus.tx_busy = 1'b1;
            n = 0;
            while (bus.req_ack == '0 && n < 10) begin
                tick();
                n++;
            end
            chk("vec_ack_lat", n, 3);
            chk("vec_ack", 32'(bus.req_ack), 32'(v.grant));
            chk("vec_latched", 32'(bus.data_to_tx), 32'(v.data));
            bus.req_valid[v.idx] = 1'b0;
            tick();
            chk("vec_ack_pulse", 32'(bus.req_ack), 0);
            chk("vec_start_low", 32'(bus.start_tx), 0);
            bus.tx_busy = 1'b0;
            tick();
            tick();
            tick();
            tick();
            chk("vec_grant_idle", 32'(bus.grant), 0);
            chk("vec_data_hold", 32'(bus.data_to_tx), 32'(v.data));
        end

        // all four pending at reset release, then 0 and 3 again
        do_reset();
        for (int i = 0; i < N; i++) begin
            qn[i] = 1;
            qd[i][0] = 8'h10 + 8'(i);
`ifdef UART_ARB_LOCK_EN
            ql[i][0] = 1'b1;
`endif
        end
        run_engine("all4");
        qn = '{1, 0, 0, 1};
        qd[0][0] = 8'h20;
        qd[3][0] = 8'h23;
        run_engine("two");

`ifdef UART_ARB_LOCK_EN
        qn = '{1, 0, 0, 0};
        qd[0][0] = 8'h30;
        ql[0][0] = 1'b1;
        run_engine("lock_pre");
        qn = '{1, 3, 0, 0};
        qd[0][0] = 8'h40;
        ql[0][0] = 1'b1;
        qd[1][0] = 8'h41;
        qd[1][1] = 8'h42;
        qd[1][2] = 8'h43;
        ql[1][0] = 1'b0;
        ql[1][1] = 1'b0;
        ql[1][2] = 1'b1;
        run_engine("lock");
`endif

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                qn[i] = $urandom_range(5, 0);
                for (int j = 0; j < 8; j++) begin
                    qd[i][j] = 8'($urandom);
`ifdef UART_ARB_LOCK_EN
                    ql[i][j] = (j == qn[i] - 1) ? 1'b1 : 1'($urandom);
`endif
                end
            end
            run_engine("rand");
        end

        // start timeout with tx_busy stuck low
        do_reset();
        bus.req_valid[1] = 1'b1;
        bus.req_data[15:8] = 8'h77;
        tick();
        chk("tmo_start", 32'(bus.start_tx), 1);
        chk("tmo_grant", 32'(bus.grant), 32'h2);
        n = 0;
        while (bus.start_tx && n < 5000) begin
            n++;
            tick();
        end
        chk("tmo_len", n, TMO);
        chk("tmo_err", 32'(bus.tx_err), 1);
        chk("tmo_grant_clr", 32'(bus.grant), 0);
        chk("tmo_no_ack", 32'(bus.req_ack), 0);
        tick();
        chk("tmo_err_pulse", 32'(bus.tx_err), 0);
        chk("tmo_retry", 32'(bus.start_tx), 1);
        chk("tmo_retry_grant", 32'(bus.grant), 32'h2);

        // reset while the frame is still on the line
        do_reset();
        bus.req_valid[2] = 1'b1;
        bus.req_data[23:16] = 8'h5A;
        tick();
        chk("rw_start", 32'(bus.start_tx), 1);
        bus.tx_busy = 1'b1;
        n = 0;
        while (bus.req_ack == '0 && n < 10) begin
            tick();
            n++;
        end
        chk("rw_ack", 32'(bus.req_ack), 32'h4);
        bus.req_data[23:16] = 8'h6B;
        tick();
        chk("rw_grant_wait", 32'(bus.grant), 32'h4);
        #2;
        reset = 1'b0;
        #1;
        chk("rw_async_clear", 32'({bus.start_tx, bus.grant, bus.data_to_tx,
                                   bus.req_ack, bus.tx_err}), 0);
        tick();
        tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | bus.start_tx | (|bus.grant);
        end
        chk("rw_hold_busy", 32'(seen), 0);
        bus.tx_busy = 1'b0;
        n = 0;
        while (!bus.start_tx && n < 10) begin
            tick();
            n++;
        end
        chk("rw_regrant_lat", n, 3);
        chk("rw_regrant", 32'(bus.grant), 32'h4);
        chk("rw_regrant_data", 32'(bus.data_to_tx), 32'h6B);
        do_reset();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
